// File: rtl/instruction_encode_if.sv
// Request/response bundle for the instruction encoder.
// The master drives requests and consumes encoded words; the slave is the encoder.
interface instruction_encode_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_class;
  logic [2:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, op_class, op_sel, rs, rt, rd, shamt, imm, target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, op_class, op_sel, rs, rt, rd, shamt, imm, target, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instruction_encode.sv
// Packs class/select/operand fields into MIPS-style words and streams them out
// of a small FIFO with a running word address; invalid codes are dropped and counted.
module instruction_encode #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instruction_encode_if.slave    bus,
  output logic                   err,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] level
);
  // Handshakes: a transfer happens on any rising edge where valid && ready.
  // in_ready depends only on registered occupancy, never on out_ready.
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word;
  logic              word_ok;
  logic [25:0]       rfmt;
  logic [25:0]       ifmt;
  logic              accept;
  logic              push;
  logic              pop;
  logic              bad;

  assign rfmt = {bus.rs, bus.rt, bus.rd, bus.shamt, 6'b000000};
  assign ifmt = {bus.rs, bus.rt, bus.imm};

  always_comb begin
    word    = '0;
    word_ok = 1'b1;
    case (bus.op_class)
      3'd0: begin
        word = {6'b000000, rfmt};
        case (bus.op_sel)
          3'b000:  word[5:0] = 6'b100000;
          3'b001:  word[5:0] = 6'b100010;
          3'b010:  word[5:0] = 6'b100001;
          3'b011:  word[5:0] = 6'b100011;
          3'b100:  word[5:0] = 6'b001000;
          3'b110:  word[5:0] = 6'b001001;
          default: word_ok   = 1'b0;
        endcase
      end
      3'd1: begin
        word = {6'b000000, rfmt};
        case (bus.op_sel)
          3'b000:  word[5:0] = 6'b100100;
          3'b001:  word[5:0] = 6'b100101;
          3'b010:  word[5:0] = 6'b001100;
          3'b011:  word[5:0] = 6'b001101;
          3'b100:  word[5:0] = 6'b000000;
          3'b101:  word[5:0] = 6'b000010;
          default: word_ok   = 1'b0;
        endcase
      end
      3'd2: begin
        word = {6'b000000, rfmt};
        case (bus.op_sel)
          3'b000:  word[5:0] = 6'b101010;
          3'b001:  word[5:0] = 6'b001010;
          default: word_ok   = 1'b0;
        endcase
      end
      3'd3: begin
        case (bus.op_sel)
          3'b000:  word    = {6'b100011, ifmt};
          3'b001:  word    = {6'b101011, ifmt};
          default: word_ok = 1'b0;
        endcase
      end
      3'd4: begin
        case (bus.op_sel)
          3'b000:  word    = {6'b000100, ifmt};
          3'b001:  word    = {6'b000101, ifmt};
          3'b010:  word    = {6'b000111, ifmt};
          3'b011:  word    = {6'b011000, ifmt};
          3'b100:  word    = {6'b011001, ifmt};
          3'b101:  word    = {6'b010101, ifmt};
          default: word_ok = 1'b0;
        endcase
      end
      3'd5: begin
        case (bus.op_sel)
          3'b000:  word    = {6'b000010, bus.target};
          3'b001:  word    = {6'b001000, bus.rs, 21'b0};
          3'b010:  word    = {6'b000011, bus.target};
          default: word_ok = 1'b0;
        endcase
      end
      default: word_ok = 1'b0;
    endcase
  end

  assign bus.in_ready  = (level < FULL_LVL);
  assign bus.out_valid = (level != '0);
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 32'h0;
  assign bus.out_addr  = addr_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && word_ok;
  assign bad    = accept && !word_ok;
  assign pop    = bus.out_valid && bus.out_ready;

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      addr_q    <= '0;
      err       <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      err <= bad;
      if (bad && err_count != 8'hFF) err_count <= err_count + 8'h01;
    end
  end
endmodule

// File: tb/tb_instruction_encode.sv
// Directed bench for instruction_encode: vector table, multi-cycle sequences,
// and a negedge cycle model with an expected-word queue.
module tb_instruction_encode;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic err;
  logic [7:0] err_count;
  logic [1:0] level;

  always #5 clk = ~clk;

  instruction_encode_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_encode #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .err(err), .err_count(err_count), .level(level)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        ok;
    logic [31:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]       exp_q[$];
  logic              cur_ok = 1'b0;
  logic [31:0]       cur_exp = '0;
  logic              mon_on = 1'b0;
  int                m_level = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_err = 1'b0;
  int                m_cnt = 0;
  logic              m_push, m_pop, m_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cls, input logic [2:0] sel,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [4:0] shamt, input logic [15:0] imm,
                              input logic [25:0] target, input logic ok, input logic [31:0] exp);
    vec_t v;
    v.cls = cls; v.sel = sel; v.rs = rs; v.rt = rt; v.rd = rd; v.shamt = shamt;
    v.imm = imm; v.target = target; v.ok = ok; v.exp = exp;
    return v;
  endfunction

  task automatic set_req(input vec_t v);
    bus.in_valid = 1'b1;
    bus.op_class = v.cls;
    bus.op_sel   = v.sel;
    bus.rs       = v.rs;
    bus.rt       = v.rt;
    bus.rd       = v.rd;
    bus.shamt    = v.shamt;
    bus.imm      = v.imm;
    bus.target   = v.target;
    cur_ok       = v.ok;
    cur_exp      = v.exp;
  endtask

  // Holds the request until an edge where in_ready was high, bounded by a cycle budget.
  task automatic drive(input vec_t v);
    int  budget;
    bit  done;
    logic was_ready;
    budget = 0;
    done   = 1'b0;
    set_req(v);
    while (!done) begin
      was_ready = bus.in_ready;
      @(posedge clk);
      #1;
      if (was_ready) done = 1'b1;
      else if (++budget > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: request not accepted within 100 cycles at %0t", $time);
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycle model: compare current outputs, then predict the state after the next edge.
  always @(negedge clk) begin
    if (mon_on) begin
      check("mon_level", {30'b0, level}, m_level);
      check("mon_in_ready", {31'b0, bus.in_ready}, {31'b0, (m_level < DEPTH)});
      check("mon_out_valid", {31'b0, bus.out_valid}, {31'b0, (m_level != 0)});
      check("mon_err", {31'b0, err}, {31'b0, m_err});
      check("mon_err_count", {24'b0, err_count}, m_cnt);
      if (exp_q.size() != 0) begin
        check("mon_out_instr", bus.out_instr, exp_q[0]);
        check("mon_out_addr", {22'b0, bus.out_addr}, {22'b0, m_addr});
      end
      if (!rst_n) begin
        exp_q.delete();
        m_level = 0;
        m_addr  = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
      end else begin
        m_push = bus.in_valid && (m_level < DEPTH) && cur_ok;
        m_bad  = bus.in_valid && (m_level < DEPTH) && !cur_ok;
        m_pop  = bus.out_ready && (m_level != 0);
        if (m_pop) begin
          void'(exp_q.pop_front());
          m_addr = m_addr + 1'b1;
        end
        if (m_push) exp_q.push_back(cur_exp);
        m_level = exp_q.size();
        m_err   = m_bad;
        if (m_bad && m_cnt != 255) m_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[20];
  vec_t v;
  vec_t va, vb, vc;

  initial begin
    vecs[0]  = mk(3'd0, 3'b000, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0, 1'b1, 32'h00221820);
    vecs[1]  = mk(3'd0, 3'b001, 5'd4,  5'd5, 5'd6,  5'd0, 16'h0000, 26'h0, 1'b1, 32'h00853022);
    vecs[2]  = mk(3'd0, 3'b100, 5'd0,  5'd0, 5'd0,  5'd0, 16'h0000, 26'h0, 1'b1, 32'h00000008);
    vecs[3]  = mk(3'd0, 3'b101, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0, 1'b0, 32'h0);
    vecs[4]  = mk(3'd1, 3'b101, 5'd0,  5'd9, 5'd10, 5'd4, 16'h0000, 26'h0, 1'b1, 32'h00095102);
    vecs[5]  = mk(3'd1, 3'b110, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0, 1'b0, 32'h0);
    vecs[6]  = mk(3'd2, 3'b000, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0, 1'b1, 32'h0022182A);
    vecs[7]  = mk(3'd2, 3'b010, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0, 1'b0, 32'h0);
    vecs[8]  = mk(3'd3, 3'b000, 5'd29, 5'd8, 5'd0,  5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA80004);
    vecs[9]  = mk(3'd3, 3'b001, 5'd29, 5'd8, 5'd0,  5'd0, 16'h0004, 26'h0, 1'b1, 32'hAFA80004);
    vecs[10] = mk(3'd3, 3'b010, 5'd29, 5'd8, 5'd0,  5'd0, 16'h0004, 26'h0, 1'b0, 32'h0);
    vecs[11] = mk(3'd4, 3'b000, 5'd1,  5'd2, 5'd0,  5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h1022FFFF);
    vecs[12] = mk(3'd4, 3'b101, 5'd0,  5'd0, 5'd0,  5'd0, 16'h1234, 26'h0, 1'b1, 32'h54001234);
    vecs[13] = mk(3'd4, 3'b110, 5'd1,  5'd2, 5'd0,  5'd0, 16'h1234, 26'h0, 1'b0, 32'h0);
    vecs[14] = mk(3'd5, 3'b000, 5'd0,  5'd0, 5'd0,  5'd0, 16'h0000, 26'h100, 1'b1, 32'h08000100);
    vecs[15] = mk(3'd5, 3'b001, 5'd31, 5'd5, 5'd0,  5'd0, 16'h0007, 26'h0, 1'b1, 32'h23E00000);
    vecs[16] = mk(3'd5, 3'b010, 5'd0,  5'd0, 5'd0,  5'd0, 16'h0000, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF);
    vecs[17] = mk(3'd5, 3'b011, 5'd0,  5'd0, 5'd0,  5'd0, 16'h0000, 26'h100, 1'b0, 32'h0);
    vecs[18] = mk(3'd6, 3'b000, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0, 1'b0, 32'h0);
    vecs[19] = mk(3'd7, 3'b000, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0, 1'b0, 32'h0);

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op_class = '0; bus.op_sel = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
    bus.shamt = '0; bus.imm = '0; bus.target = '0;
    @(posedge clk); #1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    check("rst_level", {30'b0, level}, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_addr", {22'b0, bus.out_addr}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_err_count", {24'b0, err_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: each vector alone into an empty FIFO with the sink ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i]);
      if (vecs[i].ok) begin
        check($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
        check($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].exp);
      end else begin
        check($sformatf("vec%0d_err", i), {31'b0, err}, 32'd1);
        check($sformatf("vec%0d_nopush", i), {30'b0, level}, 32'd0);
      end
      if (i == 0) check("t1_addr0", {22'b0, bus.out_addr}, 32'd0);
      idle(1);
      if (i == 0) begin
        check("t1_addr1", {22'b0, bus.out_addr}, 32'd1);
        check("t1_level0", {30'b0, level}, 32'd0);
      end
    end
    check("table_err_count", {24'b0, err_count}, 32'd8);
    check("table_addr", {22'b0, bus.out_addr}, 32'd12);

    // Back-to-back stream of four words.
    drive(vecs[8]);
    drive(vecs[11]);
    drive(vecs[14]);
    drive(vecs[15]);
    idle(3);
    check("b2b_addr", {22'b0, bus.out_addr}, 32'd16);

    // Backpressure: fill, hold a third request while full, release one pop.
    va = vecs[1]; vb = vecs[6]; vc = vecs[9];
    bus.out_ready = 1'b0;
    drive(va);
    drive(vb);
    check("full_level", {30'b0, level}, 32'd2);
    check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    set_req(vc);
    repeat (2) begin
      @(posedge clk); #1;
      check("full_head_stable", bus.out_instr, va.exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("pop1_level", {30'b0, level}, 32'd1);
    check("pop1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("pop1_head", bus.out_instr, vb.exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("third_level", {30'b0, level}, 32'd2);
    bus.out_ready = 1'b1;
    idle(3);
    check("drain_level", {30'b0, level}, 32'd0);

    // Invalid requests and err_count saturation from a clean reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(vecs[18]);
    drive(vecs[3]);
    drive(vecs[17]);
    idle(1);
    check("inv3_err_count", {24'b0, err_count}, 32'd3);
    check("inv3_level", {30'b0, level}, 32'd0);
    for (int i = 0; i < 260; i++) drive(vecs[18]);
    idle(1);
    check("sat_err_count", {24'b0, err_count}, 32'd255);

    // Reset mid-stream with a push and pop both requested.
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    drive(vecs[2]);
    check("pre_rst_level", {30'b0, level}, 32'd2);
    bus.out_ready = 1'b1;
    set_req(vecs[4]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("mid_rst_level", {30'b0, level}, 32'd0);
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_out_addr", {22'b0, bus.out_addr}, 32'd0);
    check("mid_rst_err_count", {24'b0, err_count}, 32'd0);
    idle(2);
    check("mid_rst_nopush", {30'b0, level}, 32'd0);

    // Address wrap: 2^ADDR_W + 2 words.
    for (int i = 0; i < (1 << ADDR_W) + 2; i++) begin
      logic [9:0] iv;
      iv = i[9:0];
      v = mk(3'd0, 3'b000, iv[4:0], iv[9:5], ~iv[4:0], 5'd0, 16'h0, 26'h0, 1'b1,
             {6'b000000, iv[4:0], iv[9:5], ~iv[4:0], 5'b00000, 6'b100000});
      drive(v);
    end
    idle(3);
    check("wrap_addr", {22'b0, bus.out_addr}, 32'd2);
    check("wrap_level", {30'b0, level}, 32'd0);

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_encode.md
Name: instruction_encode

Overview:
Inverse of the instruction decoder. It takes an operation class, a per-class operation select and operand fields, and packs them into a 32-bit MIPS-style instruction word. Encoded words are buffered in a small FIFO and streamed to instruction memory or a loader over a valid/ready interface, with a running word address. Invalid operation codes are dropped and flagged.

Parameters:
DEPTH, 2, output FIFO entries; power of two, ≥2.
ADDR_W, 10, width of out_addr word counter.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset; synchronous, active-low.
in_valid  in  1  request carries an instruction to encode.
in_ready  out  1  encoder can accept a request this cycle.
op_class  in  3  0=ALU, 1=LOG, 2=COMP, 3=DAT, 4=CON, 5=UNCON, 6..7 invalid.
op_sel  in  3  operation within the class; codes listed under Behaviour.
rs  in  5  source register.
rt  in  5  target register.
rd  in  5  destination register.
shamt  in  5  shift amount.
imm  in  16  immediate or branch offset.
target  in  26  jump target.
out_valid  out  1  FIFO head valid.
out_ready  in  1  sink accepts the head word.
out_instr  out  32  encoded word at FIFO head.
out_addr  out  ADDR_W  word address of the head word.
err  out  1  one-cycle pulse when an invalid request is accepted.
err_count  out  8  saturating count of invalid requests.
level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO emptied, level=0, out_valid=0, out_instr=0, out_addr=0, err=0, err_count=0. Reset overrides any push or pop in the same cycle. A reset mid-stream discards buffered words.
- in_ready = (level < DEPTH). It is a registered-state function only, with no combinational path from out_ready.
- Accept condition: in_valid && in_ready. Encoding is combinational. The word is written into the FIFO on the same edge, so out_valid rises the cycle after the accept when the FIFO was empty.
- R-format {6'b000000, rs, rt, rd, shamt, func}, for op_class ALU, LOG and COMP:
  - ALU: 000→100000, 001→100010, 010→100001, 011→100011, 100→001000, 110→001001. 101 and 111 are invalid.
  - LOG: 000→100100, 001→100101, 010→001100, 011→001101, 100→000000, 101→000010. 110 and 111 are invalid.
  - COMP: 000→101010, 001→001010. Other codes are invalid.
- I-format {opcode, rs, rt, imm}:
  - DAT: 000→100011 (lw), 001→101011 (sw). Other codes are invalid.
  - CON: 000→000100, 001→000101, 010→000111, 011→011000, 100→011001, 101→010101. 110 and 111 are invalid.
- UNCON:
  - 000→{000010, target}.
  - 001→{001000, rs, 21'b0} (jr).
  - 010→{000011, target}.
  - Other codes are invalid.
- Invalid request (bad op_class or op_sel):
  - Still accepted: in_ready is honoured and the handshake completes.
  - Nothing is pushed.
  - err=1 for exactly the next cycle.
  - err_count increments and saturates at 255.
- Pop: out_valid && out_ready. The head advances, and out_addr increments by 1 and wraps from 2^ADDR_W−1 to 0.
- out_instr/out_valid stay stable while out_valid && !out_ready.
- Simultaneous valid push and pop: level is unchanged and both take effect. This is possible only when 0 < level < DEPTH.
- Full: in_ready=0 and in_valid is ignored. in_ready rises the cycle after a pop.
- Empty: out_valid=0, and out_ready is ignored.
- Pointers wrap modulo DEPTH.

Test Plan:
1. After reset, in_valid=1, class ALU, sel 000, rs=1, rt=2, rd=3, shamt=0, out_ready=1 → next cycle out_valid=1, out_instr=0x00221820, out_addr=0. One cycle later out_addr=1 and level=0.
2. Back-to-back requests with out_ready=1:
   - DAT sel 000, rs=29, rt=8, imm=4 → 0x8FA80004.
   - CON sel 000, rs=1, rt=2, imm=0xFFFF → 0x1022FFFF.
   - UNCON sel 000, target=0x100 → 0x08000100.
   - UNCON sel 001, rs=31 → 0x23E00000.
   - All four appear in order with out_addr 0..3, one per cycle.
3. out_ready=0 with 3 requests, DEPTH=2:
   - After 2 accepts: level=2, in_ready=0, and the head word is held stable.
   - Raise out_ready for 1 cycle → level=1 and in_ready=1 on the next cycle. The third word is then accepted.
4. Invalid requests op_class=6, then ALU sel 101, then UNCON sel 011 → nothing pushed, level stays 0, err pulses three times, err_count=3. Then 260 invalid requests → err_count=255.
5. Stream 2^ADDR_W+2 valid words with out_ready=1 → out_addr wraps to 0 after 1023 and the last word has out_addr=1.
6. With level=2, drive rst_n=0 for one edge while out_ready=1 and in_valid=1 → level=0, out_valid=0, out_addr=0, err_count=0, and no word is pushed.
